// File: rtl/vector_adder.sv
`default_nettype none
// ============================================================================
// Module      : vector_adder
// Description : LANES-wide SIMD add/subtract with per-lane signed overflow
//               flags, a 2-entry result FIFO and a consumed-beat counter.
//               Optional macro VECTOR_ADDER_SATURATE_EN clamps overflowing
//               lanes to the signed limit instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_adder #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_y,
  output logic [LANES-1:0]       out_ovf,
  output logic [31:0]            beat_count
);

  localparam int VW = LANES * WIDTH;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  logic [VW-1:0]    w_res_y;
  logic [LANES-1:0] w_res_ovf;

  logic [1:0]       occ_q,    occ_d;
  logic [VW-1:0]    y0_q,     y0_d;
  logic [VW-1:0]    y1_q,     y1_d;
  logic [LANES-1:0] ovf0_q,   ovf0_d;
  logic [LANES-1:0] ovf1_q,   ovf1_d;
  logic [31:0]      beats_q,  beats_d;

  logic w_push;
  logic w_pop;

  // Subtract is A + ~B + 1; overflow is carry-into-MSB xor carry-out.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

    assign w_a     = in_a[i*WIDTH +: WIDTH];
    assign w_b_eff = in_sub ? ~in_b[i*WIDTH +: WIDTH] : in_b[i*WIDTH +: WIDTH];
    assign w_sum   = {1'b0, w_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, in_sub};
    assign w_ovf   = w_sum[WIDTH] ^ (w_a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum[WIDTH-1]);

`ifdef VECTOR_ADDER_SATURATE_EN
    assign w_res_y[i*WIDTH +: WIDTH] =
      !w_ovf        ? w_sum[WIDTH-1:0] :
      w_a[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                      {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_res_y[i*WIDTH +: WIDTH] = w_sum[WIDTH-1:0];
`endif
    assign w_res_ovf[i] = w_ovf;
  end

  assign in_ready   = (occ_q != OCC_FULL);
  assign out_valid  = (occ_q != OCC_EMPTY);
  assign out_y      = y0_q;
  assign out_ovf    = ovf0_q;
  assign beat_count = beats_q;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Entry 0 is always the head; entry 1 only holds data when full.
  always_comb begin
    occ_d   = occ_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    ovf0_d  = ovf0_q;
    ovf1_d  = ovf1_q;
    beats_d = beats_q;

    if (w_pop) begin
      beats_d = beats_q + 32'd1;
    end

    case (occ_q)
      OCC_EMPTY: begin
        if (w_push) begin
          y0_d   = w_res_y;
          ovf0_d = w_res_ovf;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (w_push && w_pop) begin
          y0_d   = w_res_y;
          ovf0_d = w_res_ovf;
        end else if (w_push) begin
          y1_d   = w_res_y;
          ovf1_d = w_res_ovf;
          occ_d  = OCC_FULL;
        end else if (w_pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (w_pop) begin
          y0_d   = y1_q;
          ovf0_d = ovf1_q;
          occ_d  = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q   <= OCC_EMPTY;
      y0_q    <= '0;
      y1_q    <= '0;
      ovf0_q  <= '0;
      ovf1_q  <= '0;
      beats_q <= '0;
    end else begin
      occ_q   <= occ_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      ovf0_q  <= ovf0_d;
      ovf1_q  <= ovf1_d;
      beats_q <= beats_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_adder
// Description : Self-checking bench for vector_adder (WIDTH=32, LANES=4),
//               directed corner beats plus randomized traffic against a
//               queue-based arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_adder;

  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int VW    = WIDTH * LANES;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_a;
  logic [VW-1:0] in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_y;
  logic [3:0]    out_ovf;
  logic [31:0]   beat_count;

  vector_adder #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_ovf    (out_ovf),
    .beat_count (beat_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [VW-1:0] q_y[$];
  logic [3:0]    q_o[$];
  logic [31:0]   m_count;
  int            n_acc;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: signed integer arithmetic per lane, then range test.
  task automatic model(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic sub,
                       output logic [VW-1:0] y, output logic [3:0] ovf);
    longint sa, sb, s;
    logic [63:0] su;
    y = '0;
    ovf = '0;
    for (int i = 0; i < LANES; i++) begin
      sa = longint'($signed(a[i*WIDTH +: WIDTH]));
      sb = longint'($signed(b[i*WIDTH +: WIDTH]));
      s  = sub ? sa - sb : sa + sb;
      su = s;
      ovf[i] = (s > MAXV) || (s < MINV);
`ifdef VECTOR_ADDER_SATURATE_EN
      if (s > MAXV)      y[i*WIDTH +: WIDTH] = 32'h7FFF_FFFF;
      else if (s < MINV) y[i*WIDTH +: WIDTH] = 32'h8000_0000;
      else               y[i*WIDTH +: WIDTH] = su[31:0];
`else
      y[i*WIDTH +: WIDTH] = su[31:0];
`endif
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic v, input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic sub, input logic ordy);
    logic          push, pop;
    logic [VW-1:0] ey;
    logic [3:0]    eo;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sub    = sub;
    out_ready = ordy;
    #1;
    check("in_ready",   VW'(in_ready),   VW'(q_y.size() < 2));
    check("out_valid",  VW'(out_valid),  VW'(q_y.size() > 0));
    if (q_y.size() > 0) begin
      check("out_y",   out_y,        q_y[0]);
      check("out_ovf", VW'(out_ovf), VW'(q_o[0]));
    end
    check("beat_count", VW'(beat_count), VW'(m_count));
    push = v && (q_y.size() < 2);
    pop  = ordy && (q_y.size() > 0);
    model(a, b, sub, ey, eo);
    @(posedge clock);
    if (pop) begin
      void'(q_y.pop_front());
      void'(q_o.pop_front());
      m_count = m_count + 32'd1;
    end
    if (push) begin
      q_y.push_back(ey);
      q_o.push_back(eo);
      n_acc++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_a      = {LANES{32'h1234_5678}};
    in_b      = {LANES{32'h0000_0001}};
    in_sub    = 1'b0;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    q_y.delete();
    q_o.delete();
    m_count = '0;
    check("rst_out_valid",  VW'(out_valid),  '0);
    check("rst_in_ready",   VW'(in_ready),   VW'(1));
    check("rst_out_y",      out_y,           '0);
    check("rst_out_ovf",    VW'(out_ovf),    '0);
    check("rst_beat_count", VW'(beat_count), '0);
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 6))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = rnd_word();
    return v;
  endfunction

  function automatic logic [VW-1:0] lanes4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  initial begin
    m_count = '0;
    n_acc   = 0;
    do_reset();

    // Basic add, then the two signed-overflow corners.
    step(1'b1, lanes4(1, 2, 3, 4), lanes4(10, 20, 30, 40), 1'b0, 1'b1);
    check("basic_y", out_y, lanes4(11, 22, 33, 44));
    check("basic_ovf", VW'(out_ovf), '0);
    step(1'b1, lanes4(32'h7FFF_FFFF, 5, 6, 7), lanes4(1, 1, 1, 1), 1'b0, 1'b1);
    step(1'b1, lanes4(9, 32'h8000_0000, 9, 9), lanes4(1, 1, 1, 1), 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("basic_count", VW'(beat_count), VW'(3));

    // Back-pressure: only two beats fit, then drain in order.
    n_acc = 0;
    for (int k = 0; k < 4; k++)
      step(1'b1, lanes4(100 + k, k, k, k), lanes4(1, 1, 1, 1), 1'b0, 1'b0);
    check("bp_accepted", VW'(n_acc), VW'(2));
    check("bp_in_ready", VW'(in_ready), '0);
    check("bp_head", out_y[31:0], VW'(101));
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Streaming at full rate.
    do_reset();
    n_acc = 0;
    for (int k = 0; k < 100; k++) step(1'b1, rnd_vec(), rnd_vec(), 1'($urandom), 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("stream_accepted", VW'(n_acc), VW'(100));
    check("stream_count", VW'(beat_count), VW'(100));

    // Reset while full discards everything.
    step(1'b1, rnd_vec(), rnd_vec(), 1'b0, 1'b0);
    step(1'b1, rnd_vec(), rnd_vec(), 1'b1, 1'b0);
    check("full_before_rst", VW'(in_ready), '0);
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Random traffic with random stalls on both sides.
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, rnd_vec(), rnd_vec(), 1'($urandom),
           $urandom_range(0, 3) != 0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
